// File: rtl/cu_step_sequencer.sv
// cu_step_sequencer: per-instruction step counter with bus-wait hold, early branch exit,
// HALT parking and interrupt dispatch runs.
// Optional halt-bug behaviour is enabled by defining CU_HALT_BUG_EN.
module cu_step_sequencer #(
    parameter int STEP_W    = 5,
    parameter int ISR_STEPS = 20
) (
    input  logic              i_Clk,
    input  logic              i_Reset_n,
    input  logic              i_Opcode_Valid,
    input  logic [STEP_W-1:0] i_Step_Count,
    input  logic              i_Cond_Fail,
    input  logic [STEP_W-1:0] i_Short_Count,
    input  logic              i_Mem_Step,
    input  logic              i_Mem_Ready,
    input  logic              i_Halt,
    input  logic              i_Int_Pending,
    input  logic              i_IME,
    output logic [STEP_W-1:0] o_Step,
    output logic              o_Step_Valid,
    output logic [1:0]        o_State,
    output logic              o_Done,
    output logic              o_Stall,
    output logic              o_Int_Ack,
    output logic              o_Halt_Bug
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10, ISR = 2'b11} state_t;

    localparam logic [STEP_W-1:0] ISR_END = STEP_W'(ISR_STEPS - 1);

    state_t            state;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] end_cnt;
    logic              active;
    logic              stall;
    logic              cond_cut;
    logic              done;
    logic              int_take;
    logic              halt_bug;

    // Step qualifiers: bus stall, branch shortening and end-of-run detection
    always_comb begin
        active   = (state == RUN) || (state == ISR);
        stall    = active & i_Mem_Step & ~i_Mem_Ready;
        cond_cut = (state == RUN) & ~stall & i_Cond_Fail;
        done     = active & ~stall & (cond_cut ? (i_Short_Count <= step)
                                               : (step == ((state == ISR) ? ISR_END : end_cnt)));
        int_take = (state == RUN) & i_Int_Pending & i_IME;
`ifdef CU_HALT_BUG_EN
        halt_bug = done & i_Halt & i_Int_Pending & ~i_IME;
`else
        halt_bug = 1'b0;
`endif
    end

    assign o_Step       = step;
    assign o_State      = state;
    assign o_Step_Valid = active;
    assign o_Done       = done;
    assign o_Stall      = stall;
    assign o_Int_Ack    = done & (state == ISR);
    assign o_Halt_Bug   = halt_bug;

    // Sequencer state, step index and latched end count
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state   <= IDLE;
            step    <= '0;
            end_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Opcode_Valid) begin
                        state   <= RUN;
                        step    <= '0;
                        end_cnt <= i_Step_Count;
                    end
                end
                HALT: begin
                    if (i_Int_Pending) begin
                        state <= i_IME ? ISR : IDLE;
                        step  <= '0;
                    end
                end
                default: begin
                    if (done) begin
                        step <= '0;
                        if (int_take) begin
                            state <= ISR;
                        end else if (i_Halt && !halt_bug) begin
                            state <= HALT;
                        end else if (i_Opcode_Valid) begin
                            state   <= RUN;
                            end_cnt <= i_Step_Count;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!stall) begin
                        step <= step + 1'b1;
                        if (cond_cut) end_cnt <= i_Short_Count;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cu_step_sequencer.sv
// tb_cu_step_sequencer: randomized bench for cu_step_sequencer against a run-level reference model.
module tb_cu_step_sequencer;
    localparam int STEP_W    = 5;
    localparam int ISR_STEPS = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              opv;
    logic [STEP_W-1:0] step_count;
    logic              cond_fail;
    logic [STEP_W-1:0] short_count;
    logic              mem_step;
    logic              mem_ready;
    logic              halt;
    logic              pend;
    logic              ime;
    logic [STEP_W-1:0] step;
    logic              step_valid;
    logic [1:0]        state;
    logic              done;
    logic              stall;
    logic              int_ack;
    logic              halt_bug;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase (0 idle, 1 run, 2 halt, 3 isr), position in run, last index of run
    int m_phase = 0;
    int m_pos   = 0;
    int m_last  = 0;

    cu_step_sequencer #(.STEP_W(STEP_W), .ISR_STEPS(ISR_STEPS)) dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Opcode_Valid(opv), .i_Step_Count(step_count),
        .i_Cond_Fail(cond_fail), .i_Short_Count(short_count), .i_Mem_Step(mem_step),
        .i_Mem_Ready(mem_ready), .i_Halt(halt), .i_Int_Pending(pend), .i_IME(ime),
        .o_Step(step), .o_Step_Valid(step_valid), .o_State(state), .o_Done(done),
        .o_Stall(stall), .o_Int_Ack(int_ack), .o_Halt_Bug(halt_bug)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d (phase=%0d pos=%0d t=%0t)", tag, got, exp, m_phase, m_pos, $time);
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge
    task automatic cyc();
        bit in_run, waiting, cut, last_step, bug, take;
        @(negedge clk);
        #1;
        in_run    = (m_phase == 1) || (m_phase == 3);
        waiting   = in_run && mem_step && !mem_ready;
        cut       = (m_phase == 1) && !waiting && cond_fail;
        if (!in_run || waiting) last_step = 0;
        else if (cut)           last_step = (int'(short_count) <= m_pos);
        else                    last_step = (m_pos == ((m_phase == 3) ? ISR_STEPS - 1 : m_last));
`ifdef CU_HALT_BUG_EN
        bug = last_step && halt && pend && !ime;
`else
        bug = 0;
`endif
        take = (m_phase == 1) && pend && ime;
        check("step", int'(step), m_pos);
        check("state", int'(state), m_phase);
        check("valid", int'(step_valid), int'(in_run));
        check("done", int'(done), int'(last_step));
        check("stall", int'(stall), int'(waiting));
        check("int_ack", int'(int_ack), int'(last_step && m_phase == 3));
        check("halt_bug", int'(halt_bug), int'(bug));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_phase = 0; m_pos = 0; m_last = 0;
        end else if (m_phase == 0) begin
            if (opv) begin m_phase = 1; m_pos = 0; m_last = int'(step_count); end
        end else if (m_phase == 2) begin
            if (pend) begin m_phase = ime ? 3 : 0; m_pos = 0; end
        end else if (last_step) begin
            m_pos = 0;
            if (take)             m_phase = 3;
            else if (halt && !bug) m_phase = 2;
            else if (opv)         begin m_phase = 1; m_last = int'(step_count); end
            else                  m_phase = 0;
        end else if (!waiting) begin
            m_pos++;
            if (cut) m_last = int'(short_count);
        end
    endtask

    task automatic quiet();
        rst_n = 1; opv = 0; step_count = '0; cond_fail = 0; short_count = '0;
        mem_step = 0; mem_ready = 1; halt = 0; pend = 0; ime = 0;
    endtask

    task automatic randomize_inputs();
        rst_n       = ($urandom_range(199) != 0);
        opv         = ($urandom_range(3) != 0);
        step_count  = STEP_W'($urandom_range(31));
        cond_fail   = ($urandom_range(15) == 0);
        short_count = STEP_W'($urandom_range(31));
        mem_step    = ($urandom_range(2) == 0);
        mem_ready   = ($urandom_range(4) < 3);
        halt        = ($urandom_range(5) == 0);
        pend        = ($urandom_range(6) == 0);
        ime         = ($urandom_range(1) == 1);
    endtask

    initial begin
        quiet();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        cyc();
        quiet();
        opv = 1; step_count = 5'd3;
        repeat (9) cyc();
        opv = 0;
        repeat (2) cyc();
        opv = 1; step_count = 5'd11;
        cyc();
        opv = 0;
        repeat (4) cyc();
        mem_step = 1; mem_ready = 0;
        repeat (3) cyc();
        mem_step = 0; mem_ready = 1;
        repeat (9) cyc();
        opv = 1; step_count = 5'd19;
        cyc();
        opv = 0;
        repeat (7) cyc();
        cond_fail = 1; short_count = 5'd7;
        cyc();
        cond_fail = 0;
        repeat (2) cyc();
        opv = 1; step_count = 5'd1; halt = 1;
        repeat (3) cyc();
        opv = 0; halt = 0;
        repeat (2) cyc();
        pend = 1; ime = 1;
        cyc();
        pend = 0;
        repeat (22) cyc();
        opv = 1; step_count = 5'd11;
        cyc();
        opv = 0;
        repeat (5) cyc();
        rst_n = 0;
        cyc();
        rst_n = 1;
        cyc();
        opv = 1; step_count = 5'd0; halt = 1; pend = 1; ime = 0;
        repeat (3) cyc();
        quiet();
        repeat (2) cyc();
        repeat (4000) begin
            randomize_inputs();
            cyc();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cu_step_sequencer.md
Name: cu_step_sequencer

Overview:
- Sequences the control unit's per-instruction step counter.
- Starts a step run when the decoder presents an opcode, advances one step per clock, and holds on memory wait states.
- Ends a run early when a conditional branch is not taken.
- Routes completed instructions into HALT or interrupt dispatch.
- Sits between the opcode decoder, the memory bus interface and the microcode step decode logic.

Parameters:
STEP_W, 5, width of step index and count inputs
ISR_STEPS, 20, number of steps in an interrupt dispatch run (5 M-cycles x 4 T)

Ports:
i_Clk  input  1  system clock
i_Reset_n  input  1  synchronous, active-low reset
i_Opcode_Valid  input  1  decoder holds a new opcode this cycle
i_Step_Count  input  STEP_W  last step index of that opcode (run length minus 1)
i_Cond_Fail  input  1  condition false this step; shorten run
i_Short_Count  input  STEP_W  last step index when the condition fails
i_Mem_Step  input  1  current step performs a bus access
i_Mem_Ready  input  1  bus access completes this cycle
i_Halt  input  1  current instruction is HALT
i_Int_Pending  input  1  enabled interrupt flagged (IE & IF != 0)
i_IME  input  1  interrupt master enable
o_Step  output  STEP_W  current step index
o_Step_Valid  output  1  o_Step is a live execute or dispatch step
o_State  output  2  00 IDLE, 01 RUN, 10 HALT, 11 ISR
o_Done  output  1  final step of the current run
o_Stall  output  1  step held for a bus wait
o_Int_Ack  output  1  final dispatch step; interrupt controller clears IF bit
o_Halt_Bug  output  1  halt-bug pulse (see Optional Feature)

Behaviour:
- Reset (i_Reset_n low at a rising edge):
  - o_Step=0, o_State=IDLE, latched end count=0.
  - All 1-bit outputs 0.
  - Applies mid-run: the run is dropped and no o_Done is issued.
- o_Step, o_State and end count are registered.
- o_Step_Valid, o_Done, o_Stall, o_Int_Ack and o_Halt_Bug are combinational from state and inputs.
- IDLE:
  - o_Step=0, o_Step_Valid=0.
  - i_Opcode_Valid -> RUN with step 0; end count latches i_Step_Count.
  - i_Step_Count=0 gives a one-step run.
- RUN, o_Step_Valid=1:
  - Stall: o_Stall = i_Mem_Step & ~i_Mem_Ready. While stalled, step and end count hold, o_Done=0, i_Cond_Fail is ignored.
  - Cond fail (not stalled, i_Cond_Fail=1): effective end = i_Short_Count. If i_Short_Count <= o_Step, this step is final. Otherwise end count latches i_Short_Count.
  - o_Done = ~o_Stall & (o_Step == effective end).
  - Not done: o_Step increments by 1.
- On o_Done, next state in priority order:
  1. i_Int_Pending & i_IME -> ISR, step 0. This applies even when i_Halt=1; HALT is skipped.
  2. i_Halt -> HALT.
  3. i_Opcode_Valid -> RUN, step 0, relatch i_Step_Count (back-to-back runs, no bubble).
  4. Otherwise -> IDLE.
- HALT:
  - o_Step=0, o_Step_Valid=0.
  - i_Int_Pending & i_IME -> ISR.
  - i_Int_Pending & ~i_IME -> IDLE (resume fetch, no dispatch).
  - Otherwise stays in HALT.
- ISR:
  - o_Step_Valid=1; steps 0..ISR_STEPS-1.
  - Honours bus stalls exactly as RUN; i_Cond_Fail is ignored.
  - Final step: o_Done=1 and o_Int_Ack=1 for one cycle, then the same next-state priority except interrupt re-entry. The ISR sets IME=0 externally.
- Arithmetic: step increment is STEP_W wide. Wrap past 2^STEP_W-1 cannot occur, because the counter stops at end count (at most 2^STEP_W-1).
- i_Opcode_Valid outside IDLE and the o_Done cycle is ignored.

Optional Feature:
- Macro CU_HALT_BUG_EN.
- Defined:
  - HALT completes with i_IME=0 and i_Int_Pending=1.
  - o_Halt_Bug pulses 1 on that o_Done cycle.
  - Next state follows priority items 3 and 4, skipping HALT.
- Undefined:
  - o_Halt_Bug is tied to 0.
  - Same case enters HALT, which exits to IDLE on the next cycle.

Test Plan:
- Reset, i_Opcode_Valid=1, i_Step_Count=3, no stalls -> o_Step 0,1,2,3; o_Done only at step 3; back-to-back opcode restarts at 0 the next cycle with no gap.
- i_Step_Count=11, i_Mem_Step=1 and i_Mem_Ready=0 for 3 cycles at step 4 -> o_Step holds 4 with o_Stall=1 for 3 cycles; o_Done at step 11 after 15 total cycles.
- i_Step_Count=19, i_Cond_Fail=1 with i_Short_Count=7 at step 7 -> o_Done at step 7; repeat with the pulse at step 9 (i_Short_Count=7) -> immediate o_Done at step 9.
- HALT run ends with i_Int_Pending=0 -> o_State=HALT, o_Step_Valid=0. Then i_Int_Pending=1, i_IME=1 -> ISR for 20 steps; o_Int_Ack at step 19; then IDLE.
- i_Reset_n low at step 5 of a 12-step run -> next cycle o_Step=0, o_State=IDLE, no o_Done. HALT with i_IME=0 and interrupt pending -> o_Halt_Bug=1 if CU_HALT_BUG_EN is defined, else HALT for one cycle then IDLE.
